// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - state encoding and course-gate truth tables for gate_sweep_ctrl
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bit k is the gate output expected for input vector k, vec = {a, b}
    localparam logic [3:0] EXPECT_NOTA_AND_B = 4'b0010;
    localparam logic [3:0] EXPECT_AND        = 4'b1000;
    localparam logic [3:0] EXPECT_OR         = 4'b1110;
    localparam logic [3:0] EXPECT_XOR        = 4'b0110;

endpackage

// File: rtl/sweep_settle_cnt.sv
// rtl/sweep_settle_cnt.sv - 8-bit settle down-counter, terminal flag at zero
module sweep_settle_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] load_val,
    output logic       tc
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tc = (cnt == 8'd0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweeps a gate through all input vectors and checks it; STOP_ON_ERR_EN ends at first mismatch
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int                       N_IN        = 2,
    parameter int                       STEP_CYCLES = 1,
    parameter logic [(1<<N_IN)-1:0]     EXPECT      = EXPECT_NOTA_AND_B
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_s,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err
);

`ifdef STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    localparam logic [N_IN-1:0] VEC_LAST    = '1;
    localparam logic [7:0]      SETTLE_LOAD = 8'(STEP_CYCLES - 1);

    state_t            state, state_nxt;
    logic [N_IN-1:0]   vec_nxt, first_nxt;
    logic [N_IN:0]     err_nxt;
    logic              pass_nxt;
    logic              settle_load, settle_tc, mismatch, sweep_end;

    assign mismatch  = (dut_s != EXPECT[vec]);
    assign sweep_end = (vec == VEC_LAST) || (STOP_ON_ERR && mismatch);

    sweep_settle_cnt u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (settle_load),
        .en       (state == ST_APPLY),
        .load_val (SETTLE_LOAD),
        .tc       (settle_tc)
    );

    always_comb begin
        state_nxt   = state;
        vec_nxt     = vec;
        err_nxt     = err_count;
        first_nxt   = first_err;
        pass_nxt    = pass;
        settle_load = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt   = ST_APPLY;
                    vec_nxt     = '0;
                    err_nxt     = '0;
                    first_nxt   = '0;
                    pass_nxt    = 1'b0;
                    settle_load = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (settle_tc) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_nxt = err_count + 1'b1;
                    if (err_count == '0) begin
                        first_nxt = vec;
                    end
                end
                // pass is resolved on entry to DONE so it is already valid alongside done
                if (sweep_end) begin
                    state_nxt = ST_DONE;
                    pass_nxt  = (err_nxt == '0);
                end else begin
                    state_nxt   = ST_APPLY;
                    vec_nxt     = vec + 1'b1;
                    settle_load = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            vec       <= '0;
            err_count <= '0;
            first_err <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            vec       <= vec_nxt;
            err_count <= err_nxt;
            first_err <= first_nxt;
            pass      <= pass_nxt;
        end
    end

    assign busy = (state == ST_APPLY) || (state == ST_CHECK);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - self-checking bench for gate_sweep_ctrl (two instances: 1 and 3 settle cycles)
module tb_gate_sweep_ctrl;

    localparam logic [3:0] EXP = 4'b0010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start_a, start_b, sel;
    logic [3:0] tt_a, tt_b;
    logic       dut_s_a, dut_s_b;
    logic [1:0] vec_a, vec_b, first_a, first_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [2:0] err_a, err_b;

    // Gate under test modelled as a truth table indexed by the applied vector
    assign dut_s_a = tt_a[vec_a];
    assign dut_s_b = tt_b[vec_b];

    gate_sweep_ctrl #(.N_IN(2), .STEP_CYCLES(1), .EXPECT(EXP)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dut_s(dut_s_a), .vec(vec_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_err(first_a));

    gate_sweep_ctrl #(.N_IN(2), .STEP_CYCLES(3), .EXPECT(EXP)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dut_s(dut_s_b), .vec(vec_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_err(first_b));

    logic [1:0] m_vec, m_first;
    logic       m_busy, m_done, m_pass;
    logic [2:0] m_err;
    assign m_vec   = sel ? vec_b   : vec_a;
    assign m_first = sel ? first_b : first_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_pass  = sel ? pass_b  : pass_a;
    assign m_err   = sel ? err_b   : err_a;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: mismatch statistics from the XOR of gate and expected truth tables
    function automatic void model(input logic [3:0] tt, input int s, output int e, output int f,
                                  output bit p, output int lat, output int vend);
        logic [3:0] diff;
        diff = tt ^ EXP;
        e = 0; f = 0; lat = 4 * (s + 1); vend = 3;
        for (int k = 0; k < 4; k++) begin
            if (diff[k]) begin
                if (e == 0) f = k;
                e++;
            end
        end
`ifdef STOP_ON_ERR_EN
        if (e != 0) begin
            e = 1; lat = (f + 1) * (s + 1); vend = f;
        end
`endif
        p = (e == 0);
    endfunction

    // Runs one sweep with start sampled at edge 0; lat is the edge after which done is seen
    task automatic sweep(input bit b, input logic [3:0] tt, input string tag, output int lat,
                         output logic [2:0] e, output logic [1:0] f, output logic p);
        int s, ee, ef, elat, evend;
        bit ep;
        s = b ? 3 : 1;
        model(tt, s, ee, ef, ep, elat, evend);
        @(negedge clk);
        sel = b;
        if (b) begin tt_b = tt; start_b = 1'b1; end
        else   begin tt_a = tt; start_a = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            if (m_done) begin lat = n; break; end
            chk({tag, "_busy"}, 32'(m_busy), 32'(n < elat));
            if (n < elat) chk({tag, "_vec"}, 32'(m_vec), 32'(n / (s + 1)));
            @(negedge clk);
        end
        e = m_err; f = m_first; p = m_pass;
        if (lat >= 0) begin
            @(negedge clk);
            chk({tag, "_done_pulse"}, 32'(m_done), 0);
            chk({tag, "_pass_hold"}, 32'(m_pass), 32'(ep));
            chk({tag, "_vec_hold"}, 32'(m_vec), 32'(evend));
        end
    endtask

    typedef struct {
        bit         b;
        logic [3:0] tt;
        logic [2:0] err;
        logic [1:0] first;
        logic       pass;
        int         lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int lat, ee, ef, elat, evend, dn, last;
        bit ep;
        logic [2:0] e;
        logic [1:0] f;
        logic p;

`ifdef STOP_ON_ERR_EN
        tbl[0] = '{1'b0, 4'b0010, 3'd0, 2'd0, 1'b1, 8};
        tbl[1] = '{1'b0, 4'b0000, 3'd1, 2'd1, 1'b0, 4};
        tbl[2] = '{1'b1, 4'b1101, 3'd1, 2'd0, 1'b0, 4};
        tbl[3] = '{1'b0, 4'b1000, 3'd1, 2'd1, 1'b0, 4};
        tbl[4] = '{1'b0, 4'b1111, 3'd1, 2'd0, 1'b0, 2};
        tbl[5] = '{1'b1, 4'b0010, 3'd0, 2'd0, 1'b1, 16};
`else
        tbl[0] = '{1'b0, 4'b0010, 3'd0, 2'd0, 1'b1, 8};
        tbl[1] = '{1'b0, 4'b0000, 3'd1, 2'd1, 1'b0, 8};
        tbl[2] = '{1'b1, 4'b1101, 3'd4, 2'd0, 1'b0, 16};
        tbl[3] = '{1'b0, 4'b1000, 3'd2, 2'd1, 1'b0, 8};
        tbl[4] = '{1'b0, 4'b1111, 3'd3, 2'd0, 1'b0, 8};
        tbl[5] = '{1'b1, 4'b0010, 3'd0, 2'd0, 1'b1, 16};
`endif

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        tt_a = 4'b0000; tt_b = 4'b0000;
        repeat (3) @(negedge clk);
        chk("reset_a", 32'({vec_a, busy_a, done_a, pass_a, err_a, first_a}), 0);
        chk("reset_b", 32'({vec_b, busy_b, done_b, pass_b, err_b, first_b}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            sweep(tbl[i].b, tbl[i].tt, $sformatf("tbl%0d", i), lat, e, f, p);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_first", i), 32'(f), 32'(tbl[i].first));
            chk($sformatf("tbl%0d_pass", i), 32'(p), 32'(tbl[i].pass));
        end

        // Reset at edge 4 mid-sweep, with start asserted in the same cycle
        @(negedge clk);
        sel = 1'b0; tt_a = 4'b0000; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_pre_busy", 32'(busy_a), 1);
        rst_n = 1'b0; start_a = 1'b1;
        @(negedge clk);
        chk("mid_reset", 32'({vec_a, busy_a, done_a, pass_a, err_a, first_a}), 0);
        rst_n = 1'b1; start_a = 1'b0;
        @(negedge clk);
        chk("mid_start_ignored", 32'(busy_a), 0);
        sweep(1'b0, EXP, "post_rst", lat, e, f, p);
        chk("post_rst_lat", 32'(lat), 8);
        chk("post_rst_pass", 32'(p), 1);
        chk("post_rst_err", 32'(e), 0);

        // start held high: back-to-back sweeps, done every 4*(1+1)+1 cycles
        @(negedge clk);
        sel = 1'b0; tt_a = EXP; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dn = 0; last = -1;
        for (int n = 0; n <= 26; n++) begin
            if (n % 9 < 8) chk("b2b_vec", 32'(vec_a), 32'((n % 9) / 2));
            if (done_a) begin
                chk("b2b_pass", 32'(pass_a), 1);
                if (last >= 0) chk("b2b_period", 32'(n - last), 9);
                else           chk("b2b_first", 32'(n), 8);
                last = n; dn++;
            end
            if (n == 26) start_a = 1'b0;
            @(negedge clk);
        end
        chk("b2b_count", 32'(dn), 3);
        @(negedge clk);
        chk("b2b_idle", 32'(busy_a), 0);

        // Random gates on both instances against the reference model
        for (int i = 0; i < 16; i++) begin
            bit b;
            logic [3:0] tt;
            b  = 1'($urandom_range(0, 1));
            tt = 4'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            model(tt, b ? 3 : 1, ee, ef, ep, elat, evend);
            sweep(b, tt, $sformatf("rnd%0d", i), lat, e, f, p);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_err", i), 32'(e), 32'(ee));
            chk($sformatf("rnd%0d_first", i), 32'(f), 32'(ef));
            chk($sformatf("rnd%0d_pass", i), 32'(p), 32'(ep));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
